// File: rtl/prio_enc_pkg.sv
// Shared definitions for the pending priority encoder: index-width helper,
// grant one-hot type and the "no index" constant.
package prio_enc_pkg;

  // Upper bound on request lines supported by the grant one-hot type.
  localparam int GRANT_MAX = 64;

  // Index value presented when nothing has been granted yet.
  localparam int IDX_NONE = 0;

  typedef logic [GRANT_MAX-1:0] grant_onehot_t;

  // Index width for a given number of lines; never narrower than one bit.
  function automatic int idx_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  // One-hot vector with only bit idx set.
  function automatic grant_onehot_t onehot(input int idx);
    grant_onehot_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational highest-set-bit finder: WIDTH-bit vector in, index plus found flag out.
module prio_select
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan upward so the highest set bit is the last one to overwrite idx.
  always_comb begin
    idx   = IDX_W'(IDX_NONE);
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_pending.sv
// Registered priority encoder with sticky pending bits and a valid/ready output slot.
// Optional round-robin selection is enabled by defining PRIO_ENC_RR_EN;
// without it the highest pending index always wins.
module priority_encoder_pending
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req_in,
  input  logic             enc_ready,
  output logic             enc_valid,
  output logic [IDX_W-1:0] enc_out,
  output logic [WIDTH-1:0] pending_out,
  output logic             overflow
);

  logic [WIDTH-1:0] pending_reg;
  logic             enc_valid_reg;
  logic [IDX_W-1:0] enc_out_reg;
  logic             overflow_reg;

  logic [IDX_W-1:0] sel;
  logic             found;
  logic             slot_free;
  logic             do_grant;
  grant_onehot_t    grant_full;
  logic [WIDTH-1:0] grant_onehot;

`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0]   rr_ptr;
  logic [2*WIDTH-1:0] doubled;
  logic [WIDTH-1:0]   rotated;
  logic [IDX_W-1:0]   rot_idx;
  logic [IDX_W:0]     sum;

  // Rotate so that index rr_ptr-1 lands on the top bit; the finder's
  // highest-first scan then walks downward from there and wraps.
  always_comb begin
    doubled = {pending_reg, pending_reg};
    rotated = WIDTH'(doubled >> rr_ptr);
  end

  prio_select #(.WIDTH(WIDTH)) u_sel (
    .vec   (rotated),
    .idx   (rot_idx),
    .found (found)
  );

  // Undo the rotation: add rr_ptr back modulo WIDTH.
  always_comb begin
    sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
    if (sum >= (IDX_W+1)'(WIDTH)) begin
      sel = IDX_W'(sum - (IDX_W+1)'(WIDTH));
    end else begin
      sel = sum[IDX_W-1:0];
    end
  end

  // Remember the last granted index as the next search origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= IDX_W'(WIDTH - 1);
    end else if (do_grant) begin
      rr_ptr <= sel;
    end
  end
`else
  prio_select #(.WIDTH(WIDTH)) u_sel (
    .vec   (pending_reg),
    .idx   (sel),
    .found (found)
  );
`endif

  // A grant happens when the slot can take a new index and something is pending.
  always_comb begin
    slot_free    = !enc_valid_reg || enc_ready;
    do_grant     = slot_free && found;
    grant_full   = onehot(int'(sel));
    grant_onehot = do_grant ? grant_full[WIDTH-1:0] : '0;
  end

  // Pending bits: clear the granted bit, then set every requested bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= (pending_reg & ~grant_onehot) | req_in;
    end
  end

  // Output slot: load on grant, empty when free with nothing pending, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_valid_reg <= 1'b0;
      enc_out_reg   <= IDX_W'(IDX_NONE);
    end else if (slot_free) begin
      if (found) begin
        enc_valid_reg <= 1'b1;
        enc_out_reg   <= sel;
      end else begin
        enc_valid_reg <= 1'b0;
      end
    end
  end

  // Sticky overflow: a request landed on a bit still pending after this edge's grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (|(req_in & pending_reg & ~grant_onehot)) begin
      overflow_reg <= 1'b1;
    end
  end

  assign enc_valid   = enc_valid_reg;
  assign enc_out     = enc_out_reg;
  assign pending_out = pending_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_priority_encoder_pending.sv
// Self-checking bench for priority_encoder_pending (WIDTH=4); honours PRIO_ENC_RR_EN.
module tb_priority_encoder_pending;

  localparam int W  = 4;
  localparam int IW = $clog2(W);

  logic          clk;
  logic          reset;
  logic [W-1:0]  req_in;
  logic          enc_ready;
  logic          enc_valid;
  logic [IW-1:0] enc_out;
  logic [W-1:0]  pending_out;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0]  m_pend;
  logic          m_valid;
  logic [IW-1:0] m_out;
  logic          m_ovf;
  int            m_rr;

  priority_encoder_pending #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_in      (req_in),
    .enc_ready   (enc_ready),
    .enc_valid   (enc_valid),
    .enc_out     (enc_out),
    .pending_out (pending_out),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pick the next index to grant from the model's pending set, or -1.
  function automatic int model_pick();
`ifdef PRIO_ENC_RR_EN
    for (int k = 1; k <= W; k++) begin
      int i;
      i = (m_rr - k + W) % W;
      if (m_pend[i]) return i;
    end
`else
    for (int i = W - 1; i >= 0; i--) begin
      if (m_pend[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_out   = '0;
    m_ovf   = 1'b0;
    m_rr    = W - 1;
  endtask

  task automatic model_edge(input logic [W-1:0] r, input logic rd);
    logic [W-1:0] g;
    int s;
    g = '0;
    if (!m_valid || rd) begin
      s = model_pick();
      if (s >= 0) begin
        m_out   = IW'(s);
        m_valid = 1'b1;
        g[s]    = 1'b1;
        m_rr    = s;
      end else begin
        m_valid = 1'b0;
      end
    end
    if ((r & m_pend & ~g) != '0) m_ovf = 1'b1;
    m_pend = (m_pend & ~g) | r;
  endtask

  // Drive inputs for one edge, advance the model, sample 1 time unit later.
  task automatic step(input logic [W-1:0] r, input logic rd);
    req_in    = r;
    enc_ready = rd;
    @(posedge clk);
    model_edge(r, rd);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_in    = '0;
    enc_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", enc_valid); end
    checks++; if (enc_out !== 2'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", enc_out); end
    checks++; if (pending_out !== 4'h0) begin errors++; $display("FAIL reset_pending got=%0h exp=0", pending_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (pending_out !== 4'h0) begin errors++; $display("FAIL release_pending got=%0h exp=0", pending_out); end
    step(4'hF, 1'b0);
    checks++; if (pending_out !== 4'hF) begin errors++; $display("FAIL release_edge_pending got=%0h exp=f", pending_out); end
    $display("txn reset: pending=%0h after first edge", pending_out);
  endtask

  task automatic test_priority();
    do_reset();
    step(4'b0110, 1'b1);
    checks++; if (pending_out !== 4'b0110) begin errors++; $display("FAIL prio_capture got=%0h exp=6", pending_out); end
    step(4'b0000, 1'b1);
    checks++; if ({enc_valid, enc_out} !== {1'b1, 2'd2}) begin errors++; $display("FAIL prio_first got=%0b/%0d exp=1/2", enc_valid, enc_out); end
    $display("txn priority: idx=%0d", enc_out);
    step(4'b0000, 1'b1);
    checks++; if ({enc_valid, enc_out} !== {1'b1, 2'd1}) begin errors++; $display("FAIL prio_second got=%0b/%0d exp=1/1", enc_valid, enc_out); end
    $display("txn priority: idx=%0d", enc_out);
    step(4'b0000, 1'b1);
    checks++; if ({enc_valid, pending_out} !== {1'b0, 4'h0}) begin errors++; $display("FAIL prio_drain got=%0b/%0h exp=0/0", enc_valid, pending_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step((k == 2) ? 4'b0001 : 4'b0000, 1'b0);
      checks++; if ({enc_valid, enc_out} !== {1'b1, 2'd3}) begin errors++; $display("FAIL bp_hold[%0d] got=%0b/%0d exp=1/3", k, enc_valid, enc_out); end
    end
    checks++; if (pending_out !== 4'b0001) begin errors++; $display("FAIL bp_pending got=%0h exp=1", pending_out); end
    $display("txn backpressure: idx=%0d accepted", enc_out);
    step(4'b0000, 1'b1);
    checks++; if ({enc_valid, enc_out} !== {1'b1, 2'd0}) begin errors++; $display("FAIL bp_next got=%0b/%0d exp=1/0", enc_valid, enc_out); end
    $display("txn backpressure: idx=%0d", enc_out);
    step(4'b0000, 1'b1);
    checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", enc_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (3) step(4'b0011, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    repeat (2) step(4'b0000, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    $display("txn overflow: overflow=%0b", overflow);
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got=%0b exp=0", overflow); end
  endtask

  task automatic test_same_bit();
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    checks++; if ({enc_valid, enc_out, pending_out} !== {1'b1, 2'd2, 4'b0100}) begin errors++; $display("FAIL same_first got=%0b/%0d/%0h exp=1/2/4", enc_valid, enc_out, pending_out); end
    $display("txn same_bit: idx=%0d", enc_out);
    step(4'b0000, 1'b1);
    checks++; if ({enc_valid, enc_out, pending_out} !== {1'b1, 2'd2, 4'b0000}) begin errors++; $display("FAIL same_second got=%0b/%0d/%0h exp=1/2/0", enc_valid, enc_out, pending_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL same_no_ovf got=%0b exp=0", overflow); end
    $display("txn same_bit: idx=%0d", enc_out);
  endtask

  task automatic test_sequence();
    int exp_seq[5];
`ifdef PRIO_ENC_RR_EN
    exp_seq = '{2, 1, 0, 3, 2};
`else
    exp_seq = '{3, 3, 3, 3, 3};
`endif
    do_reset();
    step(4'hF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 1'b1);
      checks++; if ({enc_valid, enc_out} !== {1'b1, IW'(exp_seq[k])}) begin errors++; $display("FAIL seq[%0d] got=%0b/%0d exp=1/%0d", k, enc_valid, enc_out, exp_seq[k]); end
      $display("txn sequence: idx=%0d", enc_out);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    logic rd;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        $display("txn random: reset mid-stream at cycle %0d", n);
      end
      r  = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      rd = ($urandom_range(0, 3) != 0);
      if (enc_valid && rd) $display("txn random: idx=%0d accepted", enc_out);
      step(r, rd);
      checks++;
      if ({enc_valid, enc_out, pending_out, overflow} !== {m_valid, m_out, m_pend, m_ovf}) begin
        errors++;
        $display("FAIL random[%0d] got v=%0b o=%0d p=%0h ovf=%0b exp v=%0b o=%0d p=%0h ovf=%0b",
                 n, enc_valid, enc_out, pending_out, overflow, m_valid, m_out, m_pend, m_ovf);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_in    = '0;
    enc_ready = 1'b0;
    model_reset();
    test_reset();
    test_priority();
    test_backpressure();
    test_overflow();
    test_same_bit();
    test_sequence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
